seg7_scan_display: RTL

//   Downstream display stage for the reg-file/ALU board experiments: takes a 32-bit value
//   (register A/B/F read-out) and time-multiplexes it as 8 hex digits on the board's

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/hex_to_seg7.sv | 38 +++
 rtl/seg7_scan_display.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants and helpers for the 8-digit multiplexed 7-segment display:
//   digit count, the blank segment pattern, the 16 hex glyphs, and the helper
//   that finds which digits survive leading-zero blanking.
//   Segment bit order is {g,f,e,d,c,b,a}, active-high. The decimal point is
//   added separately as bit 7 by the display top.

package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;
    localparam int VALUE_W    = 32;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Standard common-cathode hex glyphs, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    typedef logic [3:0]            nibble_t;
    typedef logic [IDX_W-1:0]      digit_idx_t;
    typedef logic [NUM_DIGITS-1:0] digit_mask_t;

    // Bit k of the result is 1 when digit k must stay lit under leading-zero
    // blanking: some nibble at position k or above is non-zero. Digit 0 is
    // always kept so that a zero value still shows a single "0".
    function automatic digit_mask_t lz_keep_mask(input logic [VALUE_W-1:0] value);
        digit_mask_t keep;
        logic        seen_nz;
        keep    = {NUM_DIGITS{1'b0}};
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen_nz = seen_nz | (|value[4*k +: 4]);
            keep[k] = seen_nz;
        end
        keep[0] = 1'b1;
        return keep;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
//   Combinational 4-bit hex to 7-segment glyph decoder.
//   Ports:
//     nibble_i  in   4  hex digit 0..F
//     seg_o     out  7  segment pattern {g,f,e,d,c,b,a}, active-high

module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = SEG_HEX_0;
            4'h1:    seg_o = SEG_HEX_1;
            4'h2:    seg_o = SEG_HEX_2;
            4'h3:    seg_o = SEG_HEX_3;
            4'h4:    seg_o = SEG_HEX_4;
            4'h5:    seg_o = SEG_HEX_5;
            4'h6:    seg_o = SEG_HEX_6;
            4'h7:    seg_o = SEG_HEX_7;
            4'h8:    seg_o = SEG_HEX_8;
            4'h9:    seg_o = SEG_HEX_9;
            4'hA:    seg_o = SEG_HEX_A;
            4'hB:    seg_o = SEG_HEX_B;
            4'hC:    seg_o = SEG_HEX_C;
            4'hD:    seg_o = SEG_HEX_D;
            4'hE:    seg_o = SEG_HEX_E;
            4'hF:    seg_o = SEG_HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Time-multiplexes a 32-bit value as 8 hex digits on a shared 7-segment bus.
//   Each digit is held for CLK_DIV clocks. A loaded value waits in a pending
//   buffer and is committed to the displayed (shadow) value only at the
//   digit 7 -> digit 0 wrap, so a frame never mixes old and new digits.
//   Parameters:
//     CLK_DIV  clocks each digit is held (2 .. 2^20)
//     CNT_W    prescaler width, 2^CNT_W >= CLK_DIV
//   Ports:
//     clk         in   1   system clock
//     rst         in   1   synchronous reset, active-high
//     data_in     in   32  value to display
//     load        in   1   one-cycle strobe capturing data_in
//     blank_lz    in   1   blank leading zero digits (sampled on each digit tick)
//     dp_mask     in   8   dp_mask[k] lights the decimal point of digit k
//     seg         out  8   {dp,g,f,e,d,c,b,a}, active-high, registered
//     which       out  3   selected digit, registered
//     frame_done  out  1   one-cycle pulse on the digit 7 -> 0 wrap

module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100_000,
    parameter int CNT_W   = 20
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [VALUE_W-1:0]  data_in,
    input  logic                load,
    input  logic                blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [7:0]          seg,
    output logic [IDX_W-1:0]    which,
    output logic                frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam digit_idx_t       IDX_LAST = 3'd7;

    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    digit_idx_t         idx_q,      idx_d;
    logic [VALUE_W-1:0] shadow_q,   shadow_d;
    logic [VALUE_W-1:0] pending_q,  pending_d;
    logic               pend_vld_q, pend_vld_d;
    logic [7:0]         seg_q,      seg_d;
    logic               fdone_q,    fdone_d;

    logic        tick_s;
    logic        wrap_s;
    nibble_t     nibble_s;
    logic [6:0]  glyph_s;
    digit_mask_t keep_s;
    logic        blank_s;

    // Digit tick and frame wrap conditions
    always_comb begin
        tick_s = (cnt_q == CNT_MAX);
        wrap_s = tick_s && (idx_q == IDX_LAST);
    end

    // Prescaler and digit index next state
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Pending/shadow buffering. On the wrap a simultaneous load bypasses the
    // pending buffer and goes straight to the shadow, so it is never left
    // stranded for a whole extra frame.
    always_comb begin
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (wrap_s) begin
            if (load) begin
                shadow_d = data_in;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end else begin
                shadow_d = shadow_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pending_d  = data_in;
            pend_vld_d = 1'b1;
        end else begin
            pending_d  = pending_q;
            pend_vld_d = pend_vld_q;
        end
    end

    // The next digit is decoded from next-state index and shadow so that
    // digit 0 of a new frame already shows the value committed on that edge.
    always_comb begin
        nibble_s = shadow_d[{idx_d, 2'b00} +: 4];
        keep_s   = lz_keep_mask(shadow_d);
        blank_s  = blank_lz & ~keep_s[idx_d];
    end

    hex_to_seg7 u_dec (
        .nibble_i (nibble_s),
        .seg_o    (glyph_s)
    );

    // Segment output next state; the decimal point survives blanking
    always_comb begin
        seg_d   = seg_q;
        fdone_d = wrap_s;
        if (tick_s) begin
            if (blank_s) begin
                seg_d = {dp_mask[idx_d], SEG_BLANK};
            end else begin
                seg_d = {dp_mask[idx_d], glyph_s};
            end
        end else begin
            seg_d = seg_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= 3'd0;
            shadow_q   <= 32'h0000_0000;
            pending_q  <= 32'h0000_0000;
            pend_vld_q <= 1'b0;
            seg_q      <= 8'h00;
            fdone_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            fdone_q    <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign which      = idx_q;
    assign frame_done = fdone_q;

endmodule
